// File: rtl/fp_div_pkg.sv
// Shared types and width helpers for the iterative fixed-point divider.
package fp_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Left shift that aligns the dividend so the quotient lands in WFO fractional bits.
  function automatic int calc_sh(input int wf1, input int wf2, input int wfo);
    return wf2 + wfo - wf1;
  endfunction

  function automatic int calc_num_w(input int wi1, input int wf1, input int wf2, input int wfo);
    return wi1 + wf1 + calc_sh(wf1, wf2, wfo);
  endfunction

endpackage

// File: rtl/fp_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module fp_div_step #(
  parameter int WL2 = 8
) (
  input  logic [WL2:0]   rem_in,
  input  logic [WL2-1:0] divisor,
  input  logic           bit_in,
  output logic [WL2:0]   rem_out,
  output logic           q_bit
);

  logic [WL2+1:0] trial;
  logic [WL2:0]   diff;

  always_comb begin
    trial   = {rem_in, bit_in};
    q_bit   = (trial >= {2'b00, divisor});
    // When the subtraction is taken the result is below the divisor, so WL2+1 bits hold it.
    diff    = trial[WL2:0] - {1'b0, divisor};
    rem_out = q_bit ? diff : trial[WL2:0];
  end

endmodule

// File: rtl/fp_div_iter.sv
// Sequential signed fixed-point divider (radix-2 restoring on magnitudes) with saturation
// and divide-by-zero flags. Define FP_DIV_ROUND_EN for round-half-away-from-zero.
module fp_div_iter
  import fp_div_pkg::*;
#(
  parameter int WI1 = 4,
  parameter int WF1 = 4,
  parameter int WI2 = 4,
  parameter int WF2 = 4,
  parameter int WIO = 4,
  parameter int WFO = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WI1+WF1-1:0]   OP1,
  input  logic [WI2+WF2-1:0]   OP2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIO+WFO-1:0]   dout,
  output logic                 ovf,
  output logic                 dz
);

  localparam int WL1   = WI1 + WF1;
  localparam int WL2   = WI2 + WF2;
  localparam int WLO   = WIO + WFO;
  localparam int SH    = calc_sh(WF1, WF2, WFO);
  localparam int NUM_W = calc_num_w(WI1, WF1, WF2, WFO);
`ifdef FP_DIV_ROUND_EN
  localparam int QW    = NUM_W + 1;
  localparam int DSH   = SH + 1;
`else
  localparam int QW    = NUM_W;
  localparam int DSH   = SH;
`endif
  localparam int CW    = $clog2(QW);
  localparam int CMPW  = ((QW > WLO) ? QW : WLO) + 1;

  localparam logic [CW-1:0]   CNT_LAST = CW'(QW - 1);
  localparam logic [WLO-1:0]  MAX_POS  = {1'b0, {(WLO-1){1'b1}}};
  localparam logic [WLO-1:0]  MIN_NEG  = ~MAX_POS;
  localparam logic [CMPW-1:0] LIM_POS  = CMPW'((1 << (WLO-1)) - 1);
  localparam logic [CMPW-1:0] LIM_NEG  = CMPW'(1 << (WLO-1));

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [QW-1:0]   num;
  logic [WL2:0]    rem;
  logic [WL2-1:0]  div_r;
  logic            sign_r;

  logic [WL1-1:0]  mag1;
  logic [WL2-1:0]  mag2;
  logic [QW-1:0]   dividend;
  logic [WL2:0]    rem_next;
  logic            q_bit;
  logic [QW-1:0]   q_full;
  logic [CMPW-1:0] q_ext;
  logic [CMPW-1:0] lim;
  logic [WLO-1:0]  res_mag;
  logic [WLO-1:0]  res_dout;
  logic            res_ovf;

  // The most negative operand maps to 2^(W-1), which still fits unsigned in W bits.
  always_comb begin
    mag1     = OP1[WL1-1] ? (~OP1 + 1'b1) : OP1;
    mag2     = OP2[WL2-1] ? (~OP2 + 1'b1) : OP2;
    dividend = QW'(mag1) << DSH;
  end

  fp_div_step #(.WL2(WL2)) u_step (
    .rem_in  (rem),
    .divisor (div_r),
    .bit_in  (num[QW-1]),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // num shifts dividend bits out of the top while quotient bits enter at the bottom.
  always_comb begin
    q_full = {num[QW-2:0], q_bit};
`ifdef FP_DIV_ROUND_EN
    q_ext  = CMPW'(({1'b0, q_full} + 1'b1) >> 1);
`else
    q_ext  = CMPW'(q_full);
`endif
    lim      = sign_r ? LIM_NEG : LIM_POS;
    res_ovf  = (q_ext > lim);
    res_mag  = res_ovf ? lim[WLO-1:0] : q_ext[WLO-1:0];
    res_dout = sign_r ? (~res_mag + 1'b1) : res_mag;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: datapath registers are cleared too, so an aborted division leaves no stale operands.
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
      cnt       <= '0;
      num       <= '0;
      rem       <= '0;
      div_r     <= '0;
      sign_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r   <= OP1[WL1-1] ^ OP2[WL2-1];
            div_r    <= mag2;
            rem      <= '0;
            in_ready <= 1'b0;
            if (OP2 == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              dz        <= 1'b1;
              ovf       <= 1'b1;
              dout      <= OP1[WL1-1] ? MIN_NEG : MAX_POS;
            end else begin
              state <= CALC;
              num   <= dividend;
              cnt   <= CNT_LAST;
            end
          end
        end
        CALC: begin
          rem <= rem_next;
          num <= q_full;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            dout      <= res_dout;
            ovf       <= res_ovf;
            dz        <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
